// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side burst controller for a standard-mode FIFO: synchronised full/start trigger,
// drain or fixed-length bursts, registered data delivery and per-burst status.
module fifo_rd_burst_ctrl #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int READ_LAT    = 1,
   parameter int MODE        = 0,
   parameter int BURST_LEN   = 16,
   parameter int CNT_W       = 8
) (
   input  logic              rd_clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              start,
   input  logic              rd_rst_busy,
   input  logic              full,
   input  logic              almost_empty,
   input  logic              empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              burst_done,
   output logic [CNT_W-1:0]  burst_words,
   output logic              short_burst,
   output logic [31:0]       rd_total
);

   typedef enum logic [1:0] {IDLE, ARMED, READ, COOL} state_t;

   localparam logic [CNT_W-1:0] BL      = CNT_W'(BURST_LEN);
   localparam logic [2:0]       COOL_END = 3'(SYNC_STAGES - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   full_s;
   logic                   trig;
   logic [CNT_W-1:0]       beats;
   logic [CNT_W-1:0]       beat_inc;
   logic [CNT_W-1:0]       beats_nxt;
   logic [2:0]             cool_cnt;
   logic [READ_LAT-1:0]    vpipe;
   logic                   cap;
   logic                   done;
   logic                   short_set;
   logic                   clr;

   assign full_s     = sync_q[SYNC_STAGES-1];
   assign trig       = full_s | start;
   assign fifo_rd_en = (state == READ) & ~empty & ~rd_rst_busy;
   assign beat_inc   = (beats == '1) ? beats : beats + 1'b1;
   assign beats_nxt  = fifo_rd_en ? beat_inc : beats;
   assign cap        = vpipe[READ_LAT-1];

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      short_set = 1'b0;
      clr       = 1'b0;
      if (rd_rst_busy) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (en) state_nxt = ARMED;
            end
            ARMED: begin
               if (!en) begin
                  state_nxt = IDLE;
               end else if (trig) begin
                  state_nxt = READ;
                  clr       = 1'b1;
               end
            end
            READ: begin
               if (MODE == 0) begin
                  if ((fifo_rd_en && almost_empty) || empty) begin
                     state_nxt = COOL;
                     done      = 1'b1;
                  end
               end else begin
                  if (fifo_rd_en && beats_nxt >= BL) begin
                     state_nxt = COOL;
                     done      = 1'b1;
                  end else if (empty) begin
                     state_nxt = COOL;
                     done      = 1'b1;
                     short_set = 1'b1;
                  end
               end
            end
            COOL: begin
               // Wait out the synchroniser so a stale full_s cannot retrigger
               if (cool_cnt == COOL_END) state_nxt = en ? ARMED : IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         sync_q      <= '0;
         beats       <= '0;
         cool_cnt    <= '0;
         vpipe       <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         burst_done  <= 1'b0;
         burst_words <= '0;
         short_burst <= 1'b0;
         rd_total    <= '0;
      end else begin
         state      <= state_nxt;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], full};
         beats      <= clr ? '0 : beats_nxt;
         cool_cnt   <= (state == COOL) ? cool_cnt + 3'd1 : 3'd0;
         burst_done <= done;
         rd_total   <= rd_total + 32'(fifo_rd_en);
         if (done) burst_words <= beats_nxt;
         if (clr) begin
            short_burst <= 1'b0;
         end else if (short_set) begin
            short_burst <= 1'b1;
         end
         if (rd_rst_busy) begin
            vpipe <= '0;
         end else begin
            vpipe[0] <= fifo_rd_en;
            for (int i = 1; i < READ_LAT; i++) vpipe[i] <= vpipe[i-1];
         end
         dout_valid <= cap & ~rd_rst_busy;
         if (cap && !rd_rst_busy) dout <= fifo_rd_data;
      end
   end

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Bench for fifo_rd_burst_ctrl: three controller variants share one FIFO model,
// read data is scoreboarded against the words the FIFO model hands out.
module tb_fifo_rd_burst_ctrl;

   localparam int DW    = 8;
   localparam int SS    = 2;
   localparam int RL    = 1;
   localparam int CW    = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start;
   logic          busy;
   logic          full_hold;
   logic [2:0]    en_v;
   logic          full;
   logic          ae;
   logic          empty;
   logic [DW-1:0] rdata;
   logic [2:0]    rd_en_v;
   logic [2:0]    dv_v;
   logic [2:0]    bd_v;
   logic [2:0]    sb_v;
   logic [DW-1:0] dout_v [3];
   logic [CW-1:0] bw_v [3];
   logic [31:0]   tot_v [3];

   logic [DW-1:0] mem [$];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] stage [RL];
   int            cnt;
   int            sel;
   logic          rd_seen;
   int            cyc;
   int            tests;
   int            fails;
   int            n_rd;
   int            n_dv;
   int            n_bd;
   int            first_rd;
   int            first_dv;

   assign full  = (cnt == DEPTH) | full_hold;
   assign empty = (cnt == 0);
   assign ae    = (cnt <= 2);
   assign rdata = stage[RL-1];

   fifo_rd_burst_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS), .READ_LAT(RL),
      .MODE(0), .BURST_LEN(16), .CNT_W(CW)) u_dut0 (
      .rd_clk(clk), .rst_n(rst_n), .en(en_v[0]), .start(start),
      .rd_rst_busy(busy), .full(full), .almost_empty(ae), .empty(empty),
      .fifo_rd_data(rdata), .fifo_rd_en(rd_en_v[0]), .dout(dout_v[0]),
      .dout_valid(dv_v[0]), .burst_done(bd_v[0]), .burst_words(bw_v[0]),
      .short_burst(sb_v[0]), .rd_total(tot_v[0]));

   fifo_rd_burst_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS), .READ_LAT(RL),
      .MODE(1), .BURST_LEN(4), .CNT_W(CW)) u_dut1 (
      .rd_clk(clk), .rst_n(rst_n), .en(en_v[1]), .start(start),
      .rd_rst_busy(busy), .full(full), .almost_empty(ae), .empty(empty),
      .fifo_rd_data(rdata), .fifo_rd_en(rd_en_v[1]), .dout(dout_v[1]),
      .dout_valid(dv_v[1]), .burst_done(bd_v[1]), .burst_words(bw_v[1]),
      .short_burst(sb_v[1]), .rd_total(tot_v[1]));

   fifo_rd_burst_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS), .READ_LAT(RL),
      .MODE(1), .BURST_LEN(16), .CNT_W(CW)) u_dut2 (
      .rd_clk(clk), .rst_n(rst_n), .en(en_v[2]), .start(start),
      .rd_rst_busy(busy), .full(full), .almost_empty(ae), .empty(empty),
      .fifo_rd_data(rdata), .fifo_rd_en(rd_en_v[2]), .dout(dout_v[2]),
      .dout_valid(dv_v[2]), .burst_done(bd_v[2]), .burst_words(bw_v[2]),
      .short_burst(sb_v[2]), .rd_total(tot_v[2]));

   always @(posedge clk) cyc++;

   // FIFO model: pops on a read seen in the previous cycle, data after RL edges
   always @(posedge clk) begin
      #1;
      for (int i = RL - 1; i > 0; i--) stage[i] = stage[i-1];
      if (rd_seen && mem.size() > 0) begin
         stage[0] = mem.pop_front();
         cnt--;
         exp_q.push_back(stage[0]);
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] w;
      rd_seen = rd_en_v[sel];
      if (rd_seen) begin
         n_rd++;
         if (first_rd < 0) first_rd = cyc;
         tests++;
         if (empty) begin
            fails++;
            $display("FAIL rd_while_empty dut%0d: fifo_rd_en=1 with empty=1, required 0", sel);
         end
      end
      if (dv_v[sel]) begin
         n_dv++;
         if (first_dv < 0) first_dv = cyc;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL dout_extra dut%0d: dout_valid with %h, required no word", sel, dout_v[sel]);
         end else begin
            w = exp_q.pop_front();
            if (dout_v[sel] !== w) begin
               fails++;
               $display("FAIL dout_data dut%0d: got %h, required %h", sel, dout_v[sel], w);
            end
         end
      end
      if (bd_v[sel]) n_bd++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      n_rd = 0;
      n_dv = 0;
      n_bd = 0;
      first_rd = -1;
      first_dv = -1;
   endtask

   task automatic fill(input int n, input logic [DW-1:0] base);
      @(negedge clk);
      for (int i = 0; i < n; i++) mem.push_back(base + DW'(i));
      cnt += n;
   endtask

   task automatic flush();
      @(negedge clk);
      mem.delete();
      exp_q.delete();
      cnt = 0;
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int i;
      for (i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (bd_v[sel]) break;
      end
      tests++;
      if (i == maxc) begin
         fails++;
         $display("FAIL done_timeout dut%0d: no burst_done in %0d cycles, required one", sel, maxc);
      end
   endtask

   task automatic wait_rd(input int maxc);
      int i;
      for (i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (rd_en_v[sel]) break;
      end
      tests++;
      if (i == maxc) begin
         fails++;
         $display("FAIL rd_timeout dut%0d: no fifo_rd_en in %0d cycles, required one", sel, maxc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({rd_en_v[i], dv_v[i], bd_v[i], sb_v[i]} !== 4'b0 || dout_v[i] !== '0 ||
             bw_v[i] !== '0 || tot_v[i] !== 32'd0) begin
            fails++;
            $display("FAIL reset dut%0d: rd_en=%b dv=%b bd=%b sb=%b dout=%h bw=%0d tot=%0d, required all 0",
                     i, rd_en_v[i], dv_v[i], bd_v[i], sb_v[i], dout_v[i], bw_v[i], tot_v[i]);
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_mode0_drain();
      int k;
      sel = 0;
      clr_counts();
      en_v[0] = 1'b1;
      repeat (2) tick();
      fill(16, 8'h10);
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (rd_en_v[0]) begin
            k = i;
            break;
         end
      end
      tests++;
      if (k !== SS + 1) begin
         fails++;
         $display("FAIL m0_latency: first read %0d cycles after full, required %0d", k, SS + 1);
      end
      wait_done(60);
      tests++;
      if (n_rd !== 15 || bw_v[0] !== 8'd15 || cnt !== 1) begin
         fails++;
         $display("FAIL m0_burst: reads=%0d words=%0d left=%0d, required 15 15 1", n_rd, bw_v[0], cnt);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (n_dv !== 15 || exp_q.size() !== 0 || n_bd !== 1) begin
         fails++;
         $display("FAIL m0_deliver: valids=%0d pending=%0d dones=%0d, required 15 0 1", n_dv, exp_q.size(), n_bd);
      end
      en_v[0] = 1'b0;
      flush();
   endtask

   task automatic test_mode1_fixed();
      sel = 1;
      en_v[1] = 1'b1;
      repeat (2) tick();
      fill(10, 8'h40);
      clr_counts();
      pulse_start();
      wait_done(30);
      tests++;
      if (n_rd !== 4 || bw_v[1] !== 8'd4 || sb_v[1] !== 1'b0) begin
         fails++;
         $display("FAIL m1_fixed: reads=%0d words=%0d short=%b, required 4 4 0", n_rd, bw_v[1], sb_v[1]);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (n_dv !== 4 || first_dv - first_rd !== RL + 1 || exp_q.size() !== 0) begin
         fails++;
         $display("FAIL m1_valid: valids=%0d latency=%0d pending=%0d, required 4 %0d 0",
                  n_dv, first_dv - first_rd, exp_q.size(), RL + 1);
      end
      tests++;
      if (tot_v[1] !== 32'd4 || cnt !== 6) begin
         fails++;
         $display("FAIL m1_total: rd_total=%0d left=%0d, required 4 6", tot_v[1], cnt);
      end
      en_v[1] = 1'b0;
      flush();
   endtask

   task automatic test_short_burst();
      sel = 2;
      en_v[2] = 1'b1;
      repeat (2) tick();
      fill(5, 8'h80);
      clr_counts();
      pulse_start();
      wait_done(40);
      tests++;
      if (n_rd !== 5 || bw_v[2] !== 8'd5 || sb_v[2] !== 1'b1 || rd_en_v[2] !== 1'b0) begin
         fails++;
         $display("FAIL short: reads=%0d words=%0d short=%b rd_en=%b, required 5 5 1 0",
                  n_rd, bw_v[2], sb_v[2], rd_en_v[2]);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (n_dv !== 5 || exp_q.size() !== 0) begin
         fails++;
         $display("FAIL short_deliver: valids=%0d pending=%0d, required 5 0", n_dv, exp_q.size());
      end
      en_v[2] = 1'b0;
      flush();
   endtask

   task automatic test_rd_rst_busy();
      sel = 1;
      en_v[1] = 1'b1;
      repeat (2) tick();
      fill(10, 8'h20);
      clr_counts();
      pulse_start();
      wait_rd(10);
      tick();
      tick();
      busy = 1'b1;
      @(negedge clk);
      tests++;
      if (rd_en_v[1] !== 1'b0) begin
         fails++;
         $display("FAIL busy_rd_en: got %b, required 0", rd_en_v[1]);
      end
      tick();
      tests++;
      if (u_dut1.state !== 2'd0) begin
         fails++;
         $display("FAIL busy_state: got %0d, required 0 (IDLE)", u_dut1.state);
      end
      busy = 1'b0;
      repeat (6) @(negedge clk);
      tests++;
      if (n_rd !== 2 || n_bd !== 0 || n_dv !== 1 || exp_q.size() !== 1) begin
         fails++;
         $display("FAIL busy_abort: reads=%0d dones=%0d valids=%0d dropped=%0d, required 2 0 1 1",
                  n_rd, n_bd, n_dv, exp_q.size());
      end
      tests++;
      if (tot_v[1] !== 32'd6 || bw_v[1] !== 8'd4) begin
         fails++;
         $display("FAIL busy_status: rd_total=%0d words=%0d, required 6 4", tot_v[1], bw_v[1]);
      end
      en_v[1] = 1'b0;
      flush();
   endtask

   task automatic test_cool_full();
      int run1;
      int gap;
      int run2;
      sel = 1;
      clr_counts();
      en_v[1] = 1'b1;
      repeat (2) tick();
      full_hold = 1'b1;
      fill(16, 8'h60);
      run1 = 0;
      gap = 0;
      run2 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rd_en_v[1]) begin
            if (gap == 0) run1++;
            else run2++;
         end else if (run2 > 0) begin
            break;
         end else if (run1 > 0) begin
            gap++;
         end
      end
      en_v[1] = 1'b0;
      full_hold = 1'b0;
      tests++;
      if (run1 !== 4 || gap !== SS + 1 || run2 !== 4) begin
         fails++;
         $display("FAIL cool_retrigger: burst=%0d gap=%0d burst=%0d, required 4 %0d 4", run1, gap, run2, SS + 1);
      end
      repeat (8) tick();
      flush();
   endtask

   task automatic test_reset_mid_burst();
      sel = 1;
      en_v[1] = 1'b1;
      repeat (2) tick();
      fill(10, 8'h30);
      clr_counts();
      pulse_start();
      wait_rd(10);
      tick();
      rst_n = 1'b0;
      tick();
      tests++;
      if ({rd_en_v[1], dv_v[1], bd_v[1], sb_v[1]} !== 4'b0 || dout_v[1] !== '0 ||
          bw_v[1] !== '0 || tot_v[1] !== 32'd0) begin
         fails++;
         $display("FAIL rst_mid: rd_en=%b dv=%b bd=%b sb=%b dout=%h bw=%0d tot=%0d, required all 0",
                  rd_en_v[1], dv_v[1], bd_v[1], sb_v[1], dout_v[1], bw_v[1], tot_v[1]);
      end
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.delete();
      clr_counts();
      repeat (2) tick();
      pulse_start();
      wait_done(30);
      tests++;
      if (n_rd !== 4 || bw_v[1] !== 8'd4 || tot_v[1] !== 32'd4) begin
         fails++;
         $display("FAIL rst_resume: reads=%0d words=%0d rd_total=%0d, required 4 4 4", n_rd, bw_v[1], tot_v[1]);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (n_dv !== 4 || exp_q.size() !== 0) begin
         fails++;
         $display("FAIL rst_deliver: valids=%0d pending=%0d, required 4 0", n_dv, exp_q.size());
      end
      en_v[1] = 1'b0;
      flush();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      busy = 1'b0;
      full_hold = 1'b0;
      en_v = 3'b000;
      cnt = 0;
      sel = 0;
      rd_seen = 1'b0;
      cyc = 0;
      tests = 0;
      fails = 0;
      for (int i = 0; i < RL; i++) stage[i] = '0;
      clr_counts();
      test_reset();
      test_mode0_drain();
      test_mode1_fixed();
      test_short_burst();
      test_rd_rst_busy();
      test_cool_full();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

endmodule
